// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - tile sequencer: clear core, stream K operand beats, drain, present results
// Optional feature macro: CORE_SEQ_CTRL_ZSKIP_EN (skip all-zero operand beats, adds skip_cnt output)
module core_seq_ctrl #(
    parameter int N_GROUP  = 4,
    parameter int N_UNIT   = 4,
    parameter int N_MUL    = 4,
    parameter int DW_MUL   = 8,
    parameter int DW_ADD   = 32,
    parameter int CORE_LAT = 2,
    parameter int KW       = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [KW-1:0]                      k_steps,
    input  logic                               abort,
    output logic                               busy,
    output logic                               done,
    input  logic                               op_valid,
    output logic                               op_ready,
    input  logic [DW_MUL*N_MUL*N_GROUP-1:0]    op_a,
    input  logic [DW_MUL*N_MUL*N_UNIT-1:0]     op_b,
    output logic                               core_reset,
    output logic                               core_enable,
    output logic [DW_MUL*N_MUL*N_GROUP-1:0]    core_in_a,
    output logic [DW_MUL*N_MUL*N_UNIT-1:0]     core_in_b,
    output logic [1:0]                         core_in_valid,
    input  logic [DW_ADD*N_UNIT*N_GROUP-1:0]   core_out,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [DW_ADD*N_UNIT*N_GROUP-1:0]   res_data
`ifdef CORE_SEQ_CTRL_ZSKIP_EN
    ,
    output logic [KW-1:0]                      skip_cnt
`endif
);

    // Drain counter must hold values 0..CORE_LAT.
    localparam int DCW = $clog2(CORE_LAT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   beat_q;
    logic [DCW-1:0]  drain_q;
    logic            beat_acc;
    logic            last_beat;
    logic            drain_last;

    // A beat is only taken in FEED and never in the same cycle as a cancel.
    assign beat_acc   = op_valid && op_ready && !abort;
    assign last_beat  = beat_acc && (beat_q == (k_q - KW'(1)));
    // Final drain cycle: last beat's presentation cycle plus CORE_LAT cycles.
    assign drain_last = (state_q == S_DRAIN) && (drain_q == DCW'(CORE_LAT));

`ifdef CORE_SEQ_CTRL_ZSKIP_EN
    logic beat_zero;
    assign beat_zero = (op_a == '0) || (op_b == '0);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived outputs (no input-to-output paths on ready/valid).
    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        op_ready    = 1'b0;
        core_reset  = 1'b0;
        core_enable = 1'b0;
        res_valid   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (k_steps != '0)) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy        = 1'b1;
                core_reset  = 1'b1;
                core_enable = 1'b1;
                state_d     = S_FEED;
            end
            S_FEED: begin
                busy        = 1'b1;
                op_ready    = 1'b1;
                core_enable = 1'b1;
                if (last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy        = 1'b1;
                core_enable = 1'b1;
                if (drain_last) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Latch the tile length when a start is seen in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            k_q <= k_steps;
        end
    end

    // Accepted-beat counter, restarted on every tile clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q <= '0;
        end else if (state_q == S_CLEAR) begin
            beat_q <= '0;
        end else if (beat_acc) begin
            beat_q <= beat_q + KW'(1);
        end
    end

    // Drain cycle counter, held at zero outside DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_q <= '0;
        end else if (state_q == S_DRAIN) begin
            drain_q <= drain_q + DCW'(1);
        end else begin
            drain_q <= '0;
        end
    end

    // Register operands on each accepted beat; valid is a one-cycle strobe following the beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_in_a     <= '0;
            core_in_b     <= '0;
            core_in_valid <= 2'b00;
        end else begin
            if (beat_acc) begin
                core_in_a <= op_a;
                core_in_b <= op_b;
`ifdef CORE_SEQ_CTRL_ZSKIP_EN
                core_in_valid <= beat_zero ? 2'b00 : 2'b11;
`else
                core_in_valid <= 2'b11;
`endif
            end else begin
                core_in_valid <= 2'b00;
            end
        end
    end

    // Capture core results on the final drain cycle; held stable through OUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_data <= '0;
        end else if (drain_last && !abort) begin
            res_data <= core_out;
        end
    end

    // Completion pulse: zero-length tile in IDLE, or result handshake in OUT; suppressed by abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done <= 1'b0;
        end else begin
            done <= !abort &&
                    (((state_q == S_IDLE) && start && (k_steps == '0)) ||
                     ((state_q == S_OUT) && res_ready));
        end
    end

`ifdef CORE_SEQ_CTRL_ZSKIP_EN
    // Count beats that were accepted but withheld from the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skip_cnt <= '0;
        end else if (state_q == S_CLEAR) begin
            skip_cnt <= '0;
        end else if (beat_acc && beat_zero) begin
            skip_cnt <= skip_cnt + KW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - self-checking bench for core_seq_ctrl with behavioural core model
module tb_core_seq_ctrl;

    localparam int N_GROUP  = 4;
    localparam int N_UNIT   = 4;
    localparam int N_MUL    = 4;
    localparam int DW_MUL   = 8;
    localparam int DW_ADD   = 32;
    localparam int CORE_LAT = 2;
    localparam int KW       = 8;
    localparam int AW = DW_MUL * N_MUL * N_GROUP;
    localparam int BW = DW_MUL * N_MUL * N_UNIT;
    localparam int RW = DW_ADD * N_UNIT * N_GROUP;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] k_steps;
    logic          abort;
    logic          busy;
    logic          done;
    logic          op_valid;
    logic          op_ready;
    logic [AW-1:0] op_a;
    logic [BW-1:0] op_b;
    logic          core_reset;
    logic          core_enable;
    logic [AW-1:0] core_in_a;
    logic [BW-1:0] core_in_b;
    logic [1:0]    core_in_valid;
    logic [RW-1:0] core_out;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
`ifdef CORE_SEQ_CTRL_ZSKIP_EN
    logic [KW-1:0] skip_cnt;
`endif

    always #5 clk = ~clk;

    core_seq_ctrl #(
        .N_GROUP(N_GROUP), .N_UNIT(N_UNIT), .N_MUL(N_MUL), .DW_MUL(DW_MUL),
        .DW_ADD(DW_ADD), .CORE_LAT(CORE_LAT), .KW(KW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_steps(k_steps), .abort(abort),
        .busy(busy), .done(done), .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .core_reset(core_reset), .core_enable(core_enable),
        .core_in_a(core_in_a), .core_in_b(core_in_b), .core_in_valid(core_in_valid),
        .core_out(core_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
`ifdef CORE_SEQ_CTRL_ZSKIP_EN
        , .skip_cnt(skip_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk_v(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] add_vec(input logic [RW-1:0] x, input logic [RW-1:0] y);
        logic [RW-1:0] r;
        r = '0;
        for (int e = 0; e < N_GROUP * N_UNIT; e++)
            r[e*DW_ADD +: DW_ADD] = x[e*DW_ADD +: DW_ADD] + y[e*DW_ADD +: DW_ADD];
        return r;
    endfunction

    function automatic logic [RW-1:0] dot_all(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [RW-1:0]     r;
        logic [DW_ADD-1:0] s;
        logic [DW_ADD-1:0] pa;
        logic [DW_ADD-1:0] pb;
        r = '0;
        for (int g = 0; g < N_GROUP; g++) begin
            for (int u = 0; u < N_UNIT; u++) begin
                s = '0;
                for (int m = 0; m < N_MUL; m++) begin
                    pa = DW_ADD'(a[(g*N_MUL+m)*DW_MUL +: DW_MUL]);
                    pb = DW_ADD'(b[(u*N_MUL+m)*DW_MUL +: DW_MUL]);
                    s  = s + pa * pb;
                end
                r[(g*N_UNIT+u)*DW_ADD +: DW_ADD] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] rep(input logic [DW_ADD-1:0] e);
        logic [RW-1:0] r;
        for (int i = 0; i < N_GROUP * N_UNIT; i++) r[i*DW_ADD +: DW_ADD] = e;
        return r;
    endfunction

    // mode 0: every element = base; mode 1: element varies with row/column/beat.
    function automatic logic [AW-1:0] mk_a(input int mode, input int base, input int beat);
        logic [AW-1:0] r;
        for (int i = 0; i < N_GROUP * N_MUL; i++)
            r[i*DW_MUL +: DW_MUL] = (mode == 0) ? DW_MUL'(base)
                                    : DW_MUL'(base + 3 * (i / N_MUL) + (i % N_MUL) + beat);
        return r;
    endfunction

    function automatic logic [BW-1:0] mk_b(input int mode, input int base, input int beat);
        logic [BW-1:0] r;
        for (int i = 0; i < N_UNIT * N_MUL; i++)
            r[i*DW_MUL +: DW_MUL] = (mode == 0) ? DW_MUL'(base)
                                    : DW_MUL'(base + 5 * (i / N_MUL) + 2 * (i % N_MUL) + beat);
        return r;
    endfunction

    function automatic logic [RW-1:0] model_tile(input int k, input int mode, input int ab,
                                                 input int bb, input int zb);
        logic [RW-1:0] r;
        logic [AW-1:0] a;
        r = '0;
        for (int i = 0; i < k; i++) begin
            a = mk_a(mode, ab, i);
            if (i == zb) a = '0;
            r = add_vec(r, dot_all(a, mk_b(mode, bb, i)));
        end
        return r;
    endfunction

    // Behavioural core: accumulate on valid 2'b11, result visible CORE_LAT cycles after presentation.
    logic [RW-1:0] acc_q;
    logic [RW-1:0] core_out_q;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            core_out_q <= '0;
        end else begin
            if (core_reset) acc_q <= '0;
            else if (core_enable && core_in_valid == 2'b11)
                acc_q <= add_vec(acc_q, dot_all(core_in_a, core_in_b));
            core_out_q <= acc_q;
        end
    end
    assign core_out = core_out_q;

    // Cycle counter and output monitor / scoreboard.
    int            cyc = 0;
    int            valid_cnt = 0;
    int            done_cnt = 0;
    int            t_start = 0;
    logic [RW-1:0] exp_q[$];
    logic          prev_hold = 1'b0;
    logic [RW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk);
        #2;
        if (core_in_valid == 2'b11) valid_cnt++;
        if (done) done_cnt++;
        if (prev_hold && res_valid) chk_v("res_hold_stable", res_data, prev_data);
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL res_unexpected act=%0h exp=none", res_data);
            end else begin
                chk_v("res_data", res_data, exp_q.pop_front());
            end
        end
        prev_hold = res_valid && !res_ready;
        prev_data = res_data;
    end

    task automatic check_idle_outputs(input string tag);
        chk_i({tag, "_busy"}, int'(busy), 0);
        chk_i({tag, "_done"}, int'(done), 0);
        chk_i({tag, "_op_ready"}, int'(op_ready), 0);
        chk_i({tag, "_core_reset"}, int'(core_reset), 0);
        chk_i({tag, "_core_enable"}, int'(core_enable), 0);
        chk_i({tag, "_res_valid"}, int'(res_valid), 0);
        chk_i({tag, "_core_in_valid"}, int'(core_in_valid), 0);
        chk_v({tag, "_core_in_a"}, RW'(core_in_a), '0);
        chk_v({tag, "_core_in_b"}, RW'(core_in_b), '0);
        chk_v({tag, "_res_data"}, res_data, '0);
    endtask

    task automatic do_start(input int k);
        start   = 1'b1;
        k_steps = KW'(k);
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        if (k != 0) begin
            chk_i("clear_core_reset", int'(core_reset), 1);
            chk_i("clear_busy", int'(busy), 1);
            chk_i("clear_op_ready", int'(op_ready), 0);
        end
    endtask

    // Present k beats; returns at the negedge just after the last accepting edge.
    task automatic feed_beats(input int k, input int mode, input int ab, input int bb,
                              input int zb, input int gap, input logic [RW-1:0] exp_vec,
                              input bit push);
        int w;
        for (int i = 0; i < k; i++) begin
            if (i > 0) begin
                op_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            op_valid = 1'b1;
            op_a     = mk_a(mode, ab, i);
            if (i == zb) op_a = '0;
            op_b     = mk_b(mode, bb, i);
            w = 0;
            while (!op_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!op_ready) chk_i("op_ready_timeout", 0, 1);
            if (push && i == k - 1) exp_q.push_back(exp_vec);
            @(negedge clk);
        end
        op_valid = 1'b0;
    endtask

    task automatic run_tile(input int k, input int mode, input int ab, input int bb,
                            input int zb, input int gap, input int hold,
                            input logic [RW-1:0] exp_vec, input int exp_valid, input bit do_st);
        int lat;
        int d0;
        if (do_st) do_start(k);
        valid_cnt = 0;
        d0        = done_cnt;
        res_ready = (hold == 0);
        feed_beats(k, mode, ab, bb, zb, gap, exp_vec, 1'b1);
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk_i("res_latency", lat, CORE_LAT + 2);
        chk_i("valid_beats", valid_cnt, exp_valid);
        for (int h = 0; h < hold; h++) begin
            chk_i("hold_res_valid", int'(res_valid), 1);
            chk_i("hold_no_done", done_cnt - d0, 0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk_i("done_pulse", int'(done), 1);
        chk_i("busy_after_done", int'(busy), 0);
        if (k == 1 && gap == 0 && hold == 0)
            chk_i("min_tile_cycles", cyc - t_start, CORE_LAT + 5);
        @(negedge clk);
        chk_i("done_one_cycle", int'(done), 0);
        chk_i("done_count", done_cnt - d0, 1);
    endtask

    typedef struct {
        int                k;
        int                a;
        int                b;
        int                gap;
        int                hold;
        logic [DW_ADD-1:0] exp_elem;
        int                exp_valid;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #600000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin : main
        int  d0;
        bit  seen;

        tbl[0] = '{4, 1, 2, 0, 0, 32'd32, 4};
        tbl[1] = '{3, 3, 5, 1, 0, 32'd180, 3};
        tbl[2] = '{1, 255, 255, 0, 0, 32'd260100, 1};
        tbl[3] = '{2, 7, 9, 0, 5, 32'd504, 2};
`ifdef CORE_SEQ_CTRL_ZSKIP_EN
        tbl[4] = '{2, 0, 4, 0, 0, 32'd0, 0};
`else
        tbl[4] = '{2, 0, 4, 0, 0, 32'd0, 2};
`endif
        tbl[5] = '{255, 1, 1, 0, 0, 32'd1020, 255};

        reset = 1'b0; start = 1'b0; k_steps = '0; abort = 1'b0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_tile(tbl[i].k, 0, tbl[i].a, tbl[i].b, -1, tbl[i].gap, tbl[i].hold,
                     rep(tbl[i].exp_elem), tbl[i].exp_valid, 1'b1);

        // Element-varied data against the core model, gapped source and stalled sink.
        run_tile(3, 1, 10, 20, -1, 1, 2, model_tile(3, 1, 10, 20, -1), 3, 1'b1);

        // Zero-length tile, then a start on the very cycle done is visible.
        d0 = done_cnt;
        start = 1'b1; k_steps = '0;
        @(negedge clk);
        start = 1'b0;
        chk_i("k0_done", int'(done), 1);
        chk_i("k0_busy", int'(busy), 0);
        do_start(1);
        chk_i("k0_done_count", done_cnt - d0, 1);
        run_tile(1, 0, 2, 3, -1, 0, 0, rep(32'd24), 1, 1'b0);

        // Abort wins over start in IDLE.
        start = 1'b1; k_steps = KW'(3); abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk_i("abort_idle_busy", int'(busy), 0);
        chk_i("abort_idle_core_reset", int'(core_reset), 0);

        // Abort during DRAIN: no result, no done.
        do_start(2);
        feed_beats(2, 0, 1, 1, -1, 0, '0, 1'b0);
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_i("abort_drain_busy", int'(busy), 0);
        chk_i("abort_drain_core_enable", int'(core_enable), 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        chk_i("abort_drain_no_res", int'(seen), 0);
        chk_i("abort_drain_no_done", done_cnt - d0, 0);

        // Abort in FEED with a beat offered: beat not taken.
        do_start(3);
        op_valid = 1'b1; op_a = mk_a(0, 1, 0); op_b = mk_b(0, 1, 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; op_valid = 1'b0;
        chk_i("abort_feed_core_in_valid", int'(core_in_valid), 0);
        chk_i("abort_feed_op_ready", int'(op_ready), 0);
        chk_i("abort_feed_busy", int'(busy), 0);

        // Asynchronous reset after 2 of 4 beats, then a full tile.
        do_start(4);
        feed_beats(2, 0, 5, 6, -1, 0, '0, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        check_idle_outputs("midfeed");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_tile(4, 0, 1, 2, -1, 0, 0, rep(32'd32), 4, 1'b1);

        // Beat 2 has A all-zero: results are the 3-beat sum either way.
`ifdef CORE_SEQ_CTRL_ZSKIP_EN
        run_tile(4, 0, 1, 2, 1, 0, 0, model_tile(4, 0, 1, 2, 1), 3, 1'b1);
        chk_i("skip_cnt", int'(skip_cnt), 1);
`else
        run_tile(4, 0, 1, 2, 1, 0, 0, model_tile(4, 0, 1, 2, 1), 4, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk_i("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Sequencer for the `core` tile datapath: accepts a start command with a K-step count, clears the core accumulators, streams K operand slices (A slice `N_GROUP*N_MUL`, B slice `N_UNIT*N_MUL` elements) from an upstream valid/ready source into the core, waits for the core pipeline to drain, then holds the `N_GROUP*N_UNIT` accumulated results on a valid/ready result port. Sits between the operand fetch logic and `core`; one tile in flight at a time.

## Interface
- `N_GROUP`, 4, groups (rows of A slice)
- `N_UNIT`, 4, units (columns of B slice)
- `N_MUL`, 4, multipliers per unit (K elements per beat)
- `DW_MUL`, 8, operand element width
- `DW_ADD`, 32, accumulator element width
- `CORE_LAT`, 2, cycles from core `in_valid` to the contribution appearing on core `out`
- `KW`, 8, width of `k_steps`
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin tile; sampled only in IDLE
- `k_steps`  in  KW  beats for this tile; sampled with `start`
- `abort`  in  1  synchronous cancel
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at tile completion
- `op_valid` / `op_ready`  in / out  1 / 1  operand beat handshake
- `op_a`  in  `DW_MUL*N_MUL*N_GROUP`  A slice
- `op_b`  in  `DW_MUL*N_MUL*N_UNIT`  B slice
- `core_reset`  out  1  core accumulator clear, active-high
- `core_enable`  out  1  core enable
- `core_in_a` / `core_in_b`  out  as `op_a` / `op_b`  registered operands
- `core_in_valid`  out  2  bit0 A valid, bit1 B valid
- `core_out`  in  `DW_ADD*N_UNIT*N_GROUP`  core results
- `res_valid` / `res_ready`  out / in  1 / 1  result handshake
- `res_data`  out  `DW_ADD*N_UNIT*N_GROUP`  captured results

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, OUT.
- IDLE: `start`=1, `k_steps`!=0 -> latch count, CLEAR. `start`=1, `k_steps`==0 -> `done` pulse next cycle, stay IDLE, no result.
- CLEAR (1 cycle): `core_reset`=1, `core_enable`=1 -> FEED.
- FEED: `op_ready`=1. Each `op_valid&op_ready` beat registers `op_a`/`op_b` into `core_in_a`/`core_in_b` and drives `core_in_valid`=2'b11 for exactly the following cycle; otherwise `core_in_valid`=2'b00. Beat counter increments per accepted beat; on the `k_steps`-th beat -> DRAIN.
- DRAIN: `op_ready`=0; counter runs CORE_LAT+1 cycles (the last beat's presentation cycle plus CORE_LAT); on final cycle `core_out` is registered into `res_data` -> OUT.
- OUT: `res_valid`=1, `res_data` stable until `res_ready`=1; on handshake: `done` pulse, -> IDLE.
- `core_enable`=1 in CLEAR, FEED, DRAIN; 0 in IDLE, OUT.
- `abort`=1 in any state: next state IDLE, `res_valid`, `op_ready`, `core_in_valid` cleared, no `done`. `abort` wins over `start` in IDLE.
- Beat counter width KW; `k_steps`=2^KW-1 is legal, no wrap.

## Timing
- Reset values: state IDLE; `busy`, `done`, `op_ready`, `core_reset`, `core_enable`, `res_valid` = 0; `core_in_valid`=2'b00; `core_in_a`, `core_in_b`, `res_data` = 0.
- `start` at edge t -> CLEAR in cycle t+1, `op_ready`=1 from t+2.
- Last beat accepted at edge t -> `res_valid` high from t+CORE_LAT+2.
- Minimum tile (k_steps=1, op_valid always high, res_ready always high): `start` to `done` = CORE_LAT+5 cycles.
- `op_ready` is registered-state-driven only (no combinational path from `op_valid`); `res_valid` has no combinational path from `res_ready`.
- Back-to-back: `start` accepted the cycle after `done`.

## Configuration
- `CORE_SEQ_CTRL_ZSKIP_EN` defined: an accepted beat whose `op_a` or `op_b` is all-zero is counted but drives `core_in_valid`=2'b00 (core sees no work); output `skip_cnt` (KW bits, reset 0, cleared in CLEAR) counts skipped beats.
- Undefined: every accepted beat drives 2'b11; `skip_cnt` port absent.

## Test plan
- Reset mid-FEED (after 2 of 4 beats): all outputs return to reset values asynchronously; next `start` runs a full tile.
- k_steps=4, all A=1, B=2, op_valid continuous, res_ready=1: four `core_in_valid`=2'b11 cycles, every `res_data` element = 32, `done` one cycle.
- k_steps=3 with op_valid gapped every other cycle: exactly 3 valid core cycles, `res_valid` CORE_LAT+2 after third beat.
- res_ready held low 5 cycles in OUT: `res_valid`=1 and `res_data` unchanged throughout; `done` only after handshake.
- `abort` in DRAIN: IDLE next cycle, no `res_valid`, no `done`; `start` with k_steps=0: `done` pulse, `busy` stays 0.
- ZSKIP_EN, k_steps=4, beat 2 has A all-zero: `core_in_valid`=2'b00 for that beat, `skip_cnt`=1, results equal 3-beat sum.
